// File: rtl/moore_seek_pkg.sv
// Shared types and constants for the mod-6 Moore machine seek controller.
// Holds the controller state encoding and the machine's In=1 jump table.
package moore_seek_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } seek_state_e;

  localparam int N_STATES = 6;
  localparam int STATE_W  = 3;
  localparam int TMP_W    = 4;

  // Packed jump table, entry k at bits [3k+2:3k]: 0->3, 1->5, 2->0, 3->1, 4->2, 5->4
  localparam logic [3*N_STATES-1:0] JUMP_TBL = {3'd4, 3'd2, 3'd1, 3'd0, 3'd5, 3'd3};

  function automatic logic [STATE_W-1:0] jump_succ(input logic [STATE_W-1:0] c);
    logic [STATE_W-1:0] r;
    if (c > 3'd5) begin
      r = 3'd0;
    end else begin
      r = JUMP_TBL[int'(c) * 3 +: 3];
    end
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] plus_succ(input logic [STATE_W-1:0] c);
    logic [STATE_W-1:0] r;
    if (c >= 3'd5) begin
      r = 3'd0;
    end else begin
      r = c + 3'd1;
    end
    return r;
  endfunction

  // Forward distance (to - from) mod 6; both operands assumed in 0..5.
  function automatic logic [STATE_W-1:0] mod6_dist(input logic [STATE_W-1:0] to,
                                                   input logic [STATE_W-1:0] from);
    logic [3:0] sum;
    sum = {1'b0, to} + 4'd6 - {1'b0, from};
    if (sum >= 4'd6) begin
      sum = sum - 4'd6;
    end else begin
      sum = sum;
    end
    return sum[2:0];
  endfunction

endpackage

// File: rtl/moore_seek_path.sv
// Combinational step chooser: picks the machine input that lands closer
// (mod 6) to the target, and flags when the machine already sits on it.
module moore_seek_path
  import moore_seek_pkg::*;
(
  input  logic [TMP_W-1:0]   cur,
  input  logic [STATE_W-1:0] target,
  output logic               step_in,
  output logic               match
);

  logic [STATE_W-1:0] cur_idx_s;
  logic [STATE_W-1:0] d0_s;
  logic [STATE_W-1:0] d1_s;

  // Out-of-range machine values are folded to 0; the controller aborts on them anyway.
  always_comb begin
    if (cur > 4'd5) begin
      cur_idx_s = 3'd0;
    end else begin
      cur_idx_s = cur[STATE_W-1:0];
    end
    d0_s    = mod6_dist(target, plus_succ(cur_idx_s));
    d1_s    = mod6_dist(target, jump_succ(cur_idx_s));
    step_in = (d1_s < d0_s) ? 1'b1 : 1'b0;
    match   = (cur == {1'b0, target}) ? 1'b1 : 1'b0;
  end

endmodule

// File: rtl/moore_seek_ctrl.sv
// Seek controller steering a mod-6 Moore machine to a requested state.
// Optional macro SEEK_TIMEOUT_EN aborts a seek after MAX_STEPS unmatched cycles.
module moore_seek_ctrl
  import moore_seek_pkg::*;
#(
  parameter int MAX_STEPS = 6
) (
  input  logic               clock_div,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [STATE_W-1:0] req_target,
  output logic               req_ready,
  input  logic [TMP_W-1:0]   cur_tmp,
  output logic               step_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [3:0]         steps
);

  if (MAX_STEPS < 1 || MAX_STEPS > 15) begin : g_bad_max_steps
    $error("moore_seek_ctrl: MAX_STEPS must be within 1..15");
  end

  seek_state_e        state_q, state_d;
  logic [STATE_W-1:0] target_q, target_d;
  logic [3:0]         steps_q, steps_d;
  logic               path_step_s;
  logic               match_s;

  moore_seek_path u_path (
    .cur     (cur_tmp),
    .target  (target_q),
    .step_in (path_step_s),
    .match   (match_s)
  );

  // State, latched target and step counter registers.
  always_ff @(posedge clock_div or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      target_q <= 3'd0;
      steps_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      steps_q  <= steps_d;
    end
  end

  // Next-state, target latch and counter update.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    steps_d  = steps_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          target_d = req_target;
          steps_d  = 4'd0;
          state_d  = (req_target <= 3'd5) ? ST_SEEK : ST_ERR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEEK: begin
        if (match_s) begin
          state_d = ST_DONE;
        end else if (cur_tmp > 4'd5) begin
          state_d = ST_ERR;
`ifdef SEEK_TIMEOUT_EN
        end else if (steps_q >= 4'(MAX_STEPS)) begin
          state_d = ST_ERR;
`endif
        end else begin
          steps_d = (steps_q == 4'd15) ? 4'd15 : steps_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs; step_in stays combinational so the machine acts on it this edge.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    step_in   = 1'b0;
    steps     = steps_q;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_SEEK: begin
        busy = 1'b1;
        if (!match_s && cur_tmp <= 4'd5) begin
          step_in = path_step_s;
        end else begin
          step_in = 1'b0;
        end
      end
      ST_DONE: done = 1'b1;
      ST_ERR:  err  = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_moore_seek_ctrl.sv
// Directed bench for moore_seek_ctrl with a behavioural mod-6 machine model;
// the timeout scenario follows SEEK_TIMEOUT_EN when the macro is defined.
module tb_moore_seek_ctrl;

  logic       clock_div = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_target;
  logic       req_ready;
  logic [3:0] cur_tmp;
  logic       step_in;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] steps;

  int  tests = 0;
  int  fails = 0;
  bit  stuck = 1'b0;

  moore_seek_ctrl #(.MAX_STEPS(6)) dut (
    .clock_div  (clock_div),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_ready  (req_ready),
    .cur_tmp    (cur_tmp),
    .step_in    (step_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .steps      (steps)
  );

  always #5 clock_div = ~clock_div;

  function automatic logic [3:0] machine_next(input logic [3:0] c, input logic in_bit);
    logic [3:0] r;
    if (c > 4'd5) begin
      r = c;
    end else if (in_bit) begin
      case (c)
        4'd0: r = 4'd3;
        4'd1: r = 4'd5;
        4'd2: r = 4'd0;
        4'd3: r = 4'd1;
        4'd4: r = 4'd2;
        default: r = 4'd4;
      endcase
    end else begin
      r = (c == 4'd5) ? 4'd0 : c + 4'd1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: machine model consumes step_in on the edge, outputs sampled 2 units later.
  task automatic tick();
    logic [3:0] nxt;
    nxt = stuck ? cur_tmp : machine_next(cur_tmp, step_in);
    @(posedge clock_div);
    #1;
    cur_tmp = nxt;
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic rdy, input logic bsy,
                           input logic dn, input logic er);
    chk({tag, "_ready"}, {7'd0, req_ready}, {7'd0, rdy});
    chk({tag, "_busy"},  {7'd0, busy},      {7'd0, bsy});
    chk({tag, "_done"},  {7'd0, done},      {7'd0, dn});
    chk({tag, "_err"},   {7'd0, err},       {7'd0, er});
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_target = 3'd0;
    cur_tmp    = 4'd0;
    #2;
    chk_flags("rst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_step_in", {7'd0, step_in}, 8'd0);
    chk("rst_steps", {4'd0, steps}, 8'd0);

    // Seek 0 -> 4 using only +1 steps.
    @(negedge clock_div);
    reset = 1'b1; req_valid = 1'b1; req_target = 3'd4; cur_tmp = 4'd0;
    #1;
    chk("idle_step_in", {7'd0, step_in}, 8'd0);
    tick();
    req_valid = 1'b0;
    chk_flags("s1_acc", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s1_cur", {4'd0, cur_tmp}, 8'd1);
    chk("s1_step_c1", {7'd0, step_in}, 8'd0);
    chk("s1_steps_c1", {4'd0, steps}, 8'd0);
    tick();
    chk("s1_step_c2", {7'd0, step_in}, 8'd0);
    chk("s1_steps_c2", {4'd0, steps}, 8'd1);
    tick();
    chk("s1_step_c3", {7'd0, step_in}, 8'd0);
    tick();
    chk("s1_cur4", {4'd0, cur_tmp}, 8'd4);
    chk_flags("s1_match", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_flags("s1_done", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s1_done_steps", {4'd0, steps}, 8'd3);
    chk("s1_done_step_in", {7'd0, step_in}, 8'd0);
    tick();
    chk_flags("s1_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s1_idle_steps", {4'd0, steps}, 8'd3);

    // Jump from 1 straight to 5.
    req_valid = 1'b1; req_target = 3'd5;
    tick();
    req_valid = 1'b0;
    cur_tmp = 4'd1;
    #1;
    chk("s2_step_in", {7'd0, step_in}, 8'd1);
    chk("s2_steps0", {4'd0, steps}, 8'd0);
    tick();
    chk("s2_cur5", {4'd0, cur_tmp}, 8'd5);
    chk("s2_steps1", {4'd0, steps}, 8'd1);
    chk("s2_step_match", {7'd0, step_in}, 8'd0);
    tick();
    chk_flags("s2_done", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s2_done_steps", {4'd0, steps}, 8'd1);
    tick();
    chk_flags("s2_idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Illegal target is rejected; a request while in ERR is ignored.
    req_valid = 1'b1; req_target = 3'd6;
    tick();
    chk_flags("s3_err", 1'b0, 1'b0, 1'b0, 1'b1);
    req_target = 3'd2;
    tick();
    req_valid = 1'b0;
    chk_flags("s3_idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Invalid machine value mid-seek aborts.
    cur_tmp = 4'd0; req_valid = 1'b1; req_target = 3'd3;
    tick();
    req_valid = 1'b0;
    chk("s5_cur", {4'd0, cur_tmp}, 8'd1);
    chk("s5_step_in", {7'd0, step_in}, 8'd0);
    stuck = 1'b1;
    cur_tmp = 4'd7;
    tick();
    chk_flags("s5_err", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_flags("s5_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    stuck = 1'b0;

    // Asynchronous reset in the middle of a seek, then a fresh request.
    cur_tmp = 4'd0; req_valid = 1'b1; req_target = 3'd0;
    tick();
    req_valid = 1'b0;
    chk("s4_step_in_jump", {7'd0, step_in}, 8'd1);
    tick();
    chk("s4_cur5", {4'd0, cur_tmp}, 8'd5);
    chk("s4_steps1", {4'd0, steps}, 8'd1);
    chk("s4_busy", {7'd0, busy}, 8'd1);
    reset = 1'b0;
    #1;
    chk_flags("s4_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s4_rst_steps", {4'd0, steps}, 8'd0);
    chk("s4_rst_step_in", {7'd0, step_in}, 8'd0);
    @(negedge clock_div);
    reset = 1'b1; cur_tmp = 4'd0; req_valid = 1'b1; req_target = 3'd2;
    tick();
    req_valid = 1'b0;
    chk_flags("s4_acc", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s4_acc_steps", {4'd0, steps}, 8'd0);
    tick();
    chk("s4_cur2", {4'd0, cur_tmp}, 8'd2);
    tick();
    chk_flags("s4_done", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s4_done_steps", {4'd0, steps}, 8'd1);
    tick();

    // Machine stuck at 2 while seeking 0.
    stuck = 1'b1;
    cur_tmp = 4'd2; req_valid = 1'b1; req_target = 3'd0;
    tick();
    req_valid = 1'b0;
    chk("s6_step_in", {7'd0, step_in}, 8'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
    end
    chk("s6_steps6", {4'd0, steps}, 8'd6);
    chk("s6_busy6", {7'd0, busy}, 8'd1);
    tick();
`ifdef SEEK_TIMEOUT_EN
    chk_flags("s6_timeout_err", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s6_timeout_steps", {4'd0, steps}, 8'd6);
    tick();
    chk_flags("s6_timeout_idle", 1'b1, 1'b0, 1'b0, 1'b0);
`else
    chk_flags("s6_no_timeout", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s6_steps7", {4'd0, steps}, 8'd7);
    for (int i = 0; i < 12; i++) begin
      tick();
    end
    chk("s6_busy_late", {7'd0, busy}, 8'd1);
    chk("s6_steps_sat", {4'd0, steps}, 8'd15);
`endif
    stuck = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/moore_seek_ctrl.md
MOORE_SEEK_CTRL -- requirements
Module: moore_seek_ctrl

Interface
REQ-001 Parameter: MAX_STEPS, default 6, SEEK cycles allowed before timeout abort (used only with SEEK_TIMEOUT_EN).
REQ-002 Port: clock_div  input  1  clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  1  seek request present.
REQ-005 Port: req_target  input  3  target machine state, legal 0..5.
REQ-006 Port: req_ready  output  1  controller can accept a request; high only in IDLE.
REQ-007 Port: cur_tmp  input  4  current state value from the mod-6 Moore machine, legal 0..5.
REQ-008 Port: step_in  output  1  drives the machine's In: 0 = +1 mod 6; 1 = jump (0->3, 1->5, 2->0, 3->1, 4->2, 5->4).
REQ-009 Port: busy  output  1  high in SEEK.
REQ-010 Port: done  output  1  one-cycle pulse; target reached.
REQ-011 Port: err  output  1  one-cycle pulse; request rejected or aborted.
REQ-012 Port: steps  output  4  steps driven in the current or last seek; saturates at 15.

Function
REQ-013 States: IDLE, SEEK, DONE, ERR; state register updates on clock_div rising edge.
REQ-014 IDLE: req_ready=1, step_in=0; on req_valid=1, latch req_target; go to SEEK if target<=5, else to ERR.
REQ-015 SEEK, cur_tmp==latched target: step_in=0; next state DONE; steps unchanged.
REQ-016 SEEK, cur_tmp>5: next state ERR (invalid machine value).
REQ-017 SEEK otherwise: d0 = distance (target-succ0) mod 6, d1 = (target-succ1) mod 6, where succ0/succ1 are the In=0/In=1 successors of cur_tmp; step_in = 1 iff d1<d0; steps increments each such cycle.
REQ-018 step_in is combinational from state, cur_tmp and latched target, so the machine uses it on the same edge.
REQ-019 DONE: done=1 and step_in=0 for exactly one cycle; then IDLE. No check that the machine is still at the target.
REQ-020 ERR: err=1 and step_in=0 for exactly one cycle; then IDLE.
REQ-021 steps clears to 0 on request acceptance; it holds its value through DONE/ERR and IDLE until the next acceptance.
REQ-022 req_valid is ignored outside IDLE; no request queueing.
REQ-023 done and err never assert in the same cycle.

Reset
REQ-024 reset low forces IDLE, latched target 0, steps 0, done 0, err 0, busy 0, req_ready 1, step_in 0; this applies immediately, mid-seek included.
REQ-025 The first request is accepted on the first rising edge after reset deasserts with req_valid=1.

Configuration
REQ-026 Macro SEEK_TIMEOUT_EN defined: when steps reaches MAX_STEPS in SEEK without a match, the next state is ERR; the match check has priority in the same cycle.
REQ-027 Macro SEEK_TIMEOUT_EN undefined: no timeout. SEEK exits only on a match or an invalid cur_tmp, and the counter logic beyond steps is absent.

Structure
REQ-028 Package moore_seek_pkg: state enum, N_STATES=6, STATE_W=3, TMP_W=4, and the In=1 jump table constant.
REQ-029 Sub-module moore_seek_path: combinational; inputs cur, target; outputs step_in and a match flag; implements REQ-017.

Verification
REQ-030 Bench models the machine: reset, then cur_tmp=0 and req_valid=1 with target=4 -> accept on edge 1 (machine to 1); step_in 0,0,0 at cur 1,2,3; done pulses the cycle after cur=4 is seen; steps=3.
REQ-031 cur_tmp=1 in SEEK with target=5 -> step_in=1; machine goes to 5; done next cycle; steps=1.
REQ-032 req_target=6 in IDLE -> ERR; err pulses one cycle; done stays 0; req_ready returns high the following cycle.
REQ-033 Machine model stuck at 2 with target=0, SEEK_TIMEOUT_EN defined, MAX_STEPS=6 -> err after steps=6. Same stimulus without the macro -> busy stays high.
REQ-034 reset low asserted mid-SEEK -> all outputs take their REQ-024 values immediately; a new request after release is accepted with steps restarting at 0.
REQ-035 cur_tmp forced to 7 during SEEK -> err pulse the next cycle, then IDLE.
